tile_acc_drain: RTL and testbench

//  Downstream of the 5x5 systolic tile: captures the tile's per-column kernel

---
 rtl/tile_acc_drain.sv | 147 ++++++++++++++
 tb/tb_tile_acc_drain.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_acc_drain.sv
// Drain stage behind the systolic tile: captures per-column accumulations, rounds,
// shifts, applies optional ReLU, saturates, and queues results with credit-based intake.
module tile_acc_drain #(
  parameter int D_BW  = 8,
  parameter int AK_BW = 20,
  parameter int COLS  = 5,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_acc_vld,
  input  logic [AK_BW*COLS-1:0]   i_acc_kernel,
  output logic                    o_acc_rdy,
  input  logic [4:0]              i_shift,
  input  logic                    i_relu_en,
  input  logic                    i_clr_flags,
  output logic [D_BW*COLS-1:0]    o_ofmap,
  output logic                    o_vld,
  input  logic                    i_rdy,
  output logic                    o_sat,
  output logic                    o_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic signed [AK_BW:0] MAXV = (AK_BW+1)'((2**(D_BW-1)) - 1);
  localparam logic signed [AK_BW:0] MINV = (AK_BW+1)'(-(2**(D_BW-1)));
  localparam logic [4:0] SH_MAX = 5'(AK_BW - 1);

  // Handshakes: a beat transfers on a cycle where valid && ready are both high at
  // the rising edge; valid never depends on ready, and ready never depends on valid.

  logic                  s1_v;
  logic [AK_BW*COLS-1:0] s1_acc;
  logic [4:0]            s1_sh;
  logic                  s1_relu;
  logic                  s2_v;
  logic [D_BW*COLS-1:0]  s2_q;

  logic [D_BW*COLS-1:0]  mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [CW:0]           inflight;
  logic [4:0]            sh_clamped;

  logic [D_BW*COLS-1:0]  q_data;
  logic                  q_sat;
  logic [AK_BW-1:0]      acc_lane;
  logic signed [AK_BW:0] ext;
  logic signed [AK_BW:0] rnd;
  logic signed [AK_BW:0] t;

  // Every beat already in S1/S2 has a reserved FIFO slot, so the FIFO cannot overflow.
  assign inflight   = {1'b0, count} + (CW+1)'(s1_v) + (CW+1)'(s2_v);
  assign o_acc_rdy  = !rst && (inflight < (CW+1)'(DEPTH));
  assign accept     = i_acc_vld && o_acc_rdy;
  assign sh_clamped = (i_shift > SH_MAX) ? SH_MAX : i_shift;

  assign o_vld   = (count != '0);
  assign o_ofmap = o_vld ? mem[rd_ptr] : '0;
  assign push    = s2_v;
  assign pop     = o_vld && i_rdy;

  always_comb begin
    q_data   = '0;
    q_sat    = 1'b0;
    acc_lane = '0;
    ext      = '0;
    rnd      = '0;
    t        = '0;
    for (int c = 0; c < COLS; c++) begin
      acc_lane = s1_acc[c*AK_BW +: AK_BW];
      ext      = $signed({acc_lane[AK_BW-1], acc_lane});
      rnd      = (s1_sh == 5'd0) ? '0 : $signed((AK_BW+1)'(1) << (s1_sh - 5'd1));
      // One guard bit keeps acc + half-LSB from wrapping before the arithmetic shift.
      t        = (ext + rnd) >>> s1_sh;
      if (s1_relu && (t < 0)) t = '0;
      if (t > MAXV) begin
        t     = MAXV;
        q_sat = 1'b1;
      end else if (t < MINV) begin
        t     = MINV;
        q_sat = 1'b1;
      end
      q_data[c*D_BW +: D_BW] = t[D_BW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_acc  <= '0;
      s1_sh   <= '0;
      s1_relu <= 1'b0;
      s2_v    <= 1'b0;
      s2_q    <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_acc  <= i_acc_kernel;
        s1_sh   <= sh_clamped;
        s1_relu <= i_relu_en;
      end
      s2_v <= s1_v;
      if (s1_v) s2_q <= q_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Flags are sticky; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_sat  <= 1'b0;
      o_drop <= 1'b0;
    end else begin
      if (s1_v && q_sat)          o_sat <= 1'b1;
      else if (i_clr_flags)       o_sat <= 1'b0;
      if (i_acc_vld && !o_acc_rdy) o_drop <= 1'b1;
      else if (i_clr_flags)        o_drop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tile_acc_drain.sv
// Self-checking bench for tile_acc_drain: directed scenarios plus a scoreboard that
// pushes a model result on every accepted beat and compares on every pop.
module tb_tile_acc_drain;

  localparam int D_BW  = 8;
  localparam int AK_BW = 20;
  localparam int COLS  = 5;
  localparam int DEPTH = 4;
  localparam int OW    = D_BW * COLS;
  localparam int IW    = AK_BW * COLS;

  logic           clk;
  logic           rst;
  logic           i_acc_vld;
  logic [IW-1:0]  i_acc_kernel;
  logic           o_acc_rdy;
  logic [4:0]     i_shift;
  logic           i_relu_en;
  logic           i_clr_flags;
  logic [OW-1:0]  o_ofmap;
  logic           o_vld;
  logic           i_rdy;
  logic           o_sat;
  logic           o_drop;

  logic [OW-1:0]  exp_q[$];
  int             n_cmp;
  int             n_fail;

  tile_acc_drain #(.D_BW(D_BW), .AK_BW(AK_BW), .COLS(COLS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_acc_vld(i_acc_vld), .i_acc_kernel(i_acc_kernel),
    .o_acc_rdy(o_acc_rdy), .i_shift(i_shift), .i_relu_en(i_relu_en),
    .i_clr_flags(i_clr_flags), .o_ofmap(o_ofmap), .o_vld(o_vld), .i_rdy(i_rdy),
    .o_sat(o_sat), .o_drop(o_drop)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: integer floor division rather than shifts
  function automatic logic [OW-1:0] model_beat(input logic [IW-1:0] acc,
                                               input logic [4:0] sh_in, input logic relu);
    logic [OW-1:0]           r;
    logic signed [AK_BW-1:0] lane;
    int a, sh, num, d, q;
    r  = '0;
    sh = (int'(sh_in) >= AK_BW) ? AK_BW - 1 : int'(sh_in);
    for (int c = 0; c < COLS; c++) begin
      lane = acc[c*AK_BW +: AK_BW];
      a    = int'(lane);
      num  = a + ((sh > 0) ? (1 << (sh - 1)) : 0);
      d    = 1 << sh;
      q    = num / d;
      if (num < 0 && (num % d) != 0) q = q - 1;
      if (relu && q < 0) q = 0;
      if (q > (2**(D_BW-1)) - 1) q = (2**(D_BW-1)) - 1;
      if (q < -(2**(D_BW-1)))    q = -(2**(D_BW-1));
      r[c*D_BW +: D_BW] = q[D_BW-1:0];
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] pack_acc(input int a0, a1, a2, a3, a4);
    int v[COLS];
    logic [IW-1:0] r;
    v = '{a0, a1, a2, a3, a4};
    r = '0;
    for (int c = 0; c < COLS; c++) r[c*AK_BW +: AK_BW] = v[c][AK_BW-1:0];
    return r;
  endfunction

  function automatic logic [OW-1:0] pack_out(input int b0, b1, b2, b3, b4);
    int v[COLS];
    logic [OW-1:0] r;
    v = '{b0, b1, b2, b3, b4};
    r = '0;
    for (int c = 0; c < COLS; c++) r[c*D_BW +: D_BW] = v[c][D_BW-1:0];
    return r;
  endfunction

  // driver + scoreboard: samples mid-cycle, then advances to 1ns after the next edge
  task automatic tick();
    logic [OW-1:0] exp;
    #4;
    if (i_acc_vld && o_acc_rdy) exp_q.push_back(model_beat(i_acc_kernel, i_shift, i_relu_en));
    if (o_vld && i_rdy) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_pop: got %h, required queue entry (queue empty)", o_ofmap);
      end else begin
        exp = exp_q.pop_front();
        if (o_ofmap !== exp) begin
          n_fail++;
          $display("FAIL sb_data: got %h, required %h", o_ofmap, exp);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    i_acc_vld = 1'b0;
    i_rdy     = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || o_vld); i++) tick();
    n_cmp++;
    if (exp_q.size() != 0 || o_vld) begin
      n_fail++;
      $display("FAIL %s_drain: %0d entries left, o_vld=%b, required empty", name, exp_q.size(), o_vld);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (o_vld !== 1'b0 || o_ofmap !== '0 || o_acc_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: vld=%b ofmap=%h acc_rdy=%b, required 0/0/0", o_vld, o_ofmap, o_acc_rdy);
    end
    n_cmp++;
    if (o_sat !== 1'b0 || o_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: sat=%b drop=%b, required 0/0", o_sat, o_drop);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (o_acc_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_rdy: got %b, required 1", o_acc_rdy);
    end
  endtask

  task automatic test_latency_round(input string name);
    logic [OW-1:0] req;
    req          = pack_out(6, -6, 1, 0, 0);
    i_rdy        = 1'b0;
    i_shift      = 5'd4;
    i_relu_en    = 1'b0;
    i_acc_kernel = pack_acc(100, -100, 8, -8, 0);
    i_acc_vld    = 1'b1;
    tick();
    i_acc_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (o_vld !== (k == 2)) begin
        n_fail++;
        $display("FAIL %s_latency_c%0d: o_vld=%b, required %b", name, k, o_vld, (k == 2));
      end
      if (k < 2) tick();
    end
    n_cmp++;
    if (o_ofmap !== req) begin
      n_fail++;
      $display("FAIL %s_round: got %h, required %h", name, o_ofmap, req);
    end
    i_rdy = 1'b1;
    tick();
    n_cmp++;
    if (o_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_alone: o_vld=%b after pop, required 0", name, o_vld);
    end
  endtask

  task automatic test_sat_relu();
    logic [OW-1:0] req;
    i_rdy        = 1'b0;
    i_shift      = 5'd4;
    i_relu_en    = 1'b1;
    i_acc_kernel = pack_acc(5000, -5000, -100, 127*16, 0);
    i_acc_vld    = 1'b1;
    tick();
    i_acc_vld = 1'b0;
    tick();
    tick();
    req = pack_out(127, 0, 0, 127, 0);
    n_cmp++;
    if (o_vld !== 1'b1 || o_ofmap !== req) begin
      n_fail++;
      $display("FAIL relu_data: vld=%b got %h, required 1 / %h", o_vld, o_ofmap, req);
    end
    n_cmp++;
    if (o_sat !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_set: got %b, required 1", o_sat);
    end
    i_clr_flags = 1'b1;
    tick();
    i_clr_flags = 1'b0;
    n_cmp++;
    if (o_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clear: got %b, required 0", o_sat);
    end
    drain("relu");
    i_rdy        = 1'b0;
    i_relu_en    = 1'b0;
    i_acc_vld    = 1'b1;
    tick();
    i_acc_vld = 1'b0;
    tick();
    tick();
    req = pack_out(127, -128, -6, 127, 0);
    n_cmp++;
    if (o_ofmap !== req || o_sat !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_neg: got %h sat=%b, required %h sat=1", o_ofmap, o_sat, req);
    end
    drain("sat");
  endtask

  task automatic test_backpressure();
    i_rdy     = 1'b0;
    i_relu_en = 1'b0;
    i_acc_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_shift = 5'($urandom_range(0, 23));
      for (int c = 0; c < COLS; c++) i_acc_kernel[c*AK_BW +: AK_BW] = AK_BW'($urandom_range(0, (1 << AK_BW) - 1));
      tick();
    end
    i_acc_vld = 1'b0;
    n_cmp++;
    if (exp_q.size() != DEPTH) begin
      n_fail++;
      $display("FAIL bp_accepted: got %0d beats, required %0d", exp_q.size(), DEPTH);
    end
    n_cmp++;
    if (o_acc_rdy !== 1'b0 || o_drop !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_flags: acc_rdy=%b drop=%b, required 0/1", o_acc_rdy, o_drop);
    end
    drain("bp");
    n_cmp++;
    if (o_acc_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_rdy_return: got %b, required 1", o_acc_rdy);
    end
    i_clr_flags = 1'b1;
    tick();
    i_clr_flags = 1'b0;
    n_cmp++;
    if (o_drop !== 1'b0 || o_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL flags_clear: drop=%b sat=%b, required 0/0", o_drop, o_sat);
    end
  endtask

  task automatic test_streaming();
    int seen, gaps, rdy_low;
    seen    = 0;
    gaps    = 0;
    rdy_low = 0;
    i_rdy   = 1'b1;
    for (int i = 0; i < 32 + 10; i++) begin
      if (i < 32) begin
        i_acc_vld = 1'b1;
        i_relu_en = 1'($urandom_range(0, 1));
        i_shift   = 5'($urandom_range(0, 12));
        for (int c = 0; c < COLS; c++) i_acc_kernel[c*AK_BW +: AK_BW] = AK_BW'($urandom_range(0, (1 << AK_BW) - 1));
        if (!o_acc_rdy) rdy_low++;
      end else begin
        i_acc_vld = 1'b0;
      end
      if (o_vld) seen++;
      else if (seen > 0 && seen < 32) gaps++;
      tick();
    end
    n_cmp++;
    if (seen != 32 || gaps != 0) begin
      n_fail++;
      $display("FAIL stream_count: outputs=%0d gaps=%0d, required 32/0", seen, gaps);
    end
    n_cmp++;
    if (rdy_low != 0 || o_drop !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_flow: rdy_low=%0d drop=%b left=%0d, required 0/0/0", rdy_low, o_drop, exp_q.size());
    end
  endtask

  task automatic test_midop_reset();
    i_rdy     = 1'b0;
    i_relu_en = 1'b0;
    i_shift   = 5'd2;
    i_acc_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_acc_kernel = pack_acc(40 * (i + 1), -3, 7, 9, 11);
      tick();
    end
    i_acc_vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    n_cmp++;
    if (o_vld !== 1'b0 || o_ofmap !== '0) begin
      n_fail++;
      $display("FAIL midrst_vld: vld=%b ofmap=%h, required 0/0", o_vld, o_ofmap);
    end
    test_latency_round("midrst");
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    rst          = 1'b1;
    i_acc_vld    = 1'b0;
    i_acc_kernel = '0;
    i_shift      = '0;
    i_relu_en    = 1'b0;
    i_clr_flags  = 1'b0;
    i_rdy        = 1'b0;
    test_reset();
    test_latency_round("lat");
    test_sat_relu();
    test_backpressure();
    test_streaming();
    test_midop_reset();
    drain("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
